// File: rtl/noc_pkg.sv
// Shared NoC router definitions: port numbering, flit_id encodings and arbiter state type.
package noc_pkg;

  localparam int NUM_PORTS = 5;
  localparam int FLIT_W    = 3;

  localparam logic [2:0] PORT_L = 3'd0;
  localparam logic [2:0] PORT_N = 3'd1;
  localparam logic [2:0] PORT_E = 3'd2;
  localparam logic [2:0] PORT_W = 3'd3;
  localparam logic [2:0] PORT_S = 3'd4;

  localparam logic [FLIT_W-1:0] FLIT_HEAD      = 3'b001;
  localparam logic [FLIT_W-1:0] FLIT_BODY      = 3'b010;
  localparam logic [FLIT_W-1:0] FLIT_TAIL      = 3'b100;
  localparam logic [FLIT_W-1:0] FLIT_HEAD_TAIL = 3'b101;

  localparam int HEAD_BIT = 0;
  localparam int TAIL_BIT = 2;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_LOCKED = 1'b1
  } arb_state_t;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first requester strictly after last_ptr, wrapping L..S.
module rr_pick
  import noc_pkg::*;
(
  input  logic [NUM_PORTS-1:0] i_req,
  input  logic [2:0]           i_last_ptr,
  output logic [NUM_PORTS-1:0] o_onehot,
  output logic [2:0]           o_index,
  output logic                 o_any
);

  int w_idx;

  always_comb begin
    o_onehot = '0;
    o_index  = '0;
    o_any    = 1'b0;
    w_idx    = 0;
    for (int i = 1; i <= NUM_PORTS; i++) begin
      w_idx = (int'(i_last_ptr) + i) % NUM_PORTS;
      if (!o_any && i_req[w_idx]) begin
        o_any           = 1'b1;
        o_index         = 3'(w_idx);
        o_onehot[w_idx] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/rr_output_arbiter.sv
// Wormhole output-port arbiter: round-robin packet lock, credit flow control and stall watchdog.
//   state     | meaning
//   ST_IDLE   | no owner; arbitrate among head flits
//   ST_LOCKED | owner holds output until tail forwarded or watchdog abort
module rr_output_arbiter
  import noc_pkg::*;
#(
  parameter int CREDITS = 4,
  parameter int TIMEOUT = 255
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NUM_PORTS-1:0]        valid,
  input  logic [NUM_PORTS*FLIT_W-1:0] flit_id,
  input  logic                        credit_in,
  output logic [NUM_PORTS-1:0]        grant,
  output logic [2:0]                  sel,
  output logic                        fwd,
  output logic                        timeout
);

  localparam logic [3:0]  CREDIT_MAX = 4'(CREDITS);
  localparam logic [11:0] WD_LIMIT   = 12'(TIMEOUT);

  arb_state_t           r_state, w_state_nxt;
  logic [NUM_PORTS-1:0] r_grant, w_grant_nxt;
  logic [2:0]           r_sel, w_sel_nxt;
  logic [2:0]           r_last_ptr, w_last_ptr_nxt;
  logic                 r_timeout, w_timeout_nxt;
  logic [3:0]           r_credit_cnt, w_credit_nxt;
  logic [11:0]          r_wd_cnt, w_wd_nxt;

  logic [NUM_PORTS-1:0] w_cand;
  logic [NUM_PORTS-1:0] w_pick_onehot;
  logic [2:0]           w_pick_idx;
  logic                 w_pick_any;
  logic [FLIT_W-1:0]    w_owner_flit;
  logic                 w_fwd;
  logic                 w_tail;

  always_comb begin
    w_cand = '0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      w_cand[p] = valid[p] & flit_id[FLIT_W*p + HEAD_BIT];
    end
  end

  rr_pick u_pick (
    .i_req      (w_cand),
    .i_last_ptr (r_last_ptr),
    .o_onehot   (w_pick_onehot),
    .o_index    (w_pick_idx),
    .o_any      (w_pick_any)
  );

  // r_sel is the owner index while locked; gating with rst keeps fwd low in the reset cycle.
  assign w_owner_flit = flit_id[FLIT_W*r_sel +: FLIT_W];
  assign w_tail       = w_owner_flit[TAIL_BIT];
  assign w_fwd        = !rst && (r_state == ST_LOCKED) && valid[r_sel] && (r_credit_cnt != 4'd0);

  always_comb begin
    w_state_nxt    = r_state;
    w_grant_nxt    = r_grant;
    w_sel_nxt      = r_sel;
    w_last_ptr_nxt = r_last_ptr;
    w_timeout_nxt  = 1'b0;
    w_wd_nxt       = r_wd_cnt;
    case (r_state)
      ST_IDLE: begin
        w_wd_nxt = '0;
        if (w_pick_any) begin
          w_state_nxt = ST_LOCKED;
          w_grant_nxt = w_pick_onehot;
          w_sel_nxt   = w_pick_idx;
        end
      end
      ST_LOCKED: begin
        if (w_fwd && w_tail) begin
          w_state_nxt    = ST_IDLE;
          w_grant_nxt    = '0;
          w_sel_nxt      = '0;
          w_last_ptr_nxt = r_sel;
          w_wd_nxt       = '0;
        end else if (w_fwd) begin
          w_wd_nxt = '0;
        end else if (r_wd_cnt + 12'd1 == WD_LIMIT) begin
          w_state_nxt    = ST_IDLE;
          w_grant_nxt    = '0;
          w_sel_nxt      = '0;
          w_last_ptr_nxt = r_sel;
          w_timeout_nxt  = 1'b1;
          w_wd_nxt       = '0;
        end else begin
          w_wd_nxt = r_wd_cnt + 12'd1;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_grant_nxt = '0;
        w_sel_nxt   = '0;
        w_wd_nxt    = '0;
      end
    endcase
  end

  always_comb begin
    w_credit_nxt = r_credit_cnt;
    case ({w_fwd, credit_in})
      2'b10:   w_credit_nxt = r_credit_cnt - 4'd1;
      2'b01:   if (r_credit_cnt < CREDIT_MAX) w_credit_nxt = r_credit_cnt + 4'd1;
      default: w_credit_nxt = r_credit_cnt;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_grant      <= '0;
      r_sel        <= '0;
      r_last_ptr   <= PORT_S;
      r_timeout    <= 1'b0;
      r_credit_cnt <= CREDIT_MAX;
      r_wd_cnt     <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_grant      <= w_grant_nxt;
      r_sel        <= w_sel_nxt;
      r_last_ptr   <= w_last_ptr_nxt;
      r_timeout    <= w_timeout_nxt;
      r_credit_cnt <= w_credit_nxt;
      r_wd_cnt     <= w_wd_nxt;
    end
  end

  assign grant   = r_grant;
  assign sel     = r_sel;
  assign fwd     = w_fwd;
  assign timeout = r_timeout;

endmodule

// File: tb/tb_rr_output_arbiter.sv
// Directed bench for rr_output_arbiter (CREDITS=4, TIMEOUT=8) with hand-computed expectations.
module tb_rr_output_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  valid;
  logic [14:0] flit_id;
  logic        credit_in;
  logic [4:0]  grant;
  logic [2:0]  sel;
  logic        fwd;
  logic        timeout;

  int n_cmp = 0;
  int n_err = 0;
  int n_fwd = 0;

  localparam logic [14:0] ALL_HT = 15'b101_101_101_101_101;

  rr_output_arbiter #(.CREDITS(4), .TIMEOUT(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .valid     (valid),
    .flit_id   (flit_id),
    .credit_in (credit_in),
    .grant     (grant),
    .sel       (sel),
    .fwd       (fwd),
    .timeout   (timeout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // inputs change 1 time unit after the rising edge; checks follow 2 units later
  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [14:0] fid(input int p, input logic [2:0] t);
    logic [14:0] v;
    v = 15'(t);
    return v << (3 * p);
  endfunction

  initial begin
    rst = 1'b1; valid = '0; flit_id = '0; credit_in = 1'b0;
    nxt(); nxt();
    #2;
    chk("rst_fwd",     32'(fwd), 0);
    chk("rst_grant",   32'(grant), 0);
    chk("rst_sel",     32'(sel), 0);
    chk("rst_timeout", 32'(timeout), 0);
    chk("rst_credit",  32'(dut.r_credit_cnt), 4);

    // five single-flit packets from all ports, rotating from L
    nxt(); rst = 1'b0; valid = 5'h1F; flit_id = ALL_HT; credit_in = 1'b1;
    #2;
    chk("t1_idle_fwd",   32'(fwd), 0);
    chk("t1_idle_grant", 32'(grant), 0);
    for (int p = 0; p < 5; p++) begin
      nxt(); #2;
      chk("t1_grant", 32'(grant), 32'(1 << p));
      chk("t1_sel",   32'(sel), 32'(p));
      chk("t1_fwd",   32'(fwd), 1);
      nxt();
      if (p == 4) valid = '0;
      #2;
      chk("t1_release", 32'(grant), 0);
      chk("t1_gap_fwd", 32'(fwd), 0);
    end

    // N three-flit packet while E head waits
    nxt(); valid = 5'b00110; flit_id = fid(1, 3'b001) | fid(2, 3'b001); #2;
    chk("t2_arb", 32'(grant), 0);
    nxt(); #2;
    chk("t2_head_grant", 32'(grant), 32'h02); n_fwd += int'(fwd);
    nxt(); flit_id = fid(1, 3'b010) | fid(2, 3'b001); #2;
    chk("t2_body_grant", 32'(grant), 32'h02); n_fwd += int'(fwd);
    nxt(); flit_id = fid(1, 3'b100) | fid(2, 3'b001); #2;
    chk("t2_tail_grant", 32'(grant), 32'h02); n_fwd += int'(fwd);
    nxt(); valid = 5'b00100; #2;
    chk("t2_idle_grant", 32'(grant), 0); n_fwd += int'(fwd);
    chk("t2_n_fwd_count", 32'(n_fwd), 3);
    nxt(); #2;
    chk("t2_e_grant", 32'(grant), 32'h04);
    chk("t2_e_sel",   32'(sel), 2);
    nxt(); flit_id = fid(2, 3'b100); #2;
    chk("t2_e_tail_fwd", 32'(fwd), 1);
    nxt(); valid = '0; credit_in = 1'b0; #2;
    chk("t2_e_release", 32'(grant), 0);

    // L six-flit packet against 4 credits
    nxt(); valid = 5'b00001; flit_id = fid(0, 3'b001); #2;
    chk("t3_arb", 32'(grant), 0);
    nxt(); #2;
    chk("t3_head_fwd", 32'(fwd), 1);
    for (int i = 0; i < 3; i++) begin
      nxt(); flit_id = fid(0, 3'b010); #2;
      chk("t3_body_fwd", 32'(fwd), 1);
    end
    nxt(); #2;
    chk("t3_starved_fwd", 32'(fwd), 0);
    chk("t3_credit_zero", 32'(dut.r_credit_cnt), 0);
    nxt(); credit_in = 1'b1; #2;
    chk("t3_pulse_fwd", 32'(fwd), 0);
    nxt(); credit_in = 1'b0; #2;
    chk("t3_refill_fwd", 32'(fwd), 1);
    nxt(); credit_in = 1'b1; #2;
    chk("t3_starved2_fwd", 32'(fwd), 0);
    nxt(); credit_in = 1'b1; flit_id = fid(0, 3'b100); #2;
    chk("t3_tail_fwd",  32'(fwd), 1);
    chk("t3_credit_pre", 32'(dut.r_credit_cnt), 1);
    nxt(); valid = '0; credit_in = 1'b1; #2;
    chk("t3_release",     32'(grant), 0);
    chk("t3_credit_same", 32'(dut.r_credit_cnt), 1);
    nxt(); nxt(); nxt(); credit_in = 1'b0; #2;
    chk("t3_credit_sat", 32'(dut.r_credit_cnt), 4);

    // W owner goes silent after head: watchdog abort after 8 stall cycles
    nxt(); valid = 5'b01000; flit_id = fid(3, 3'b001); #2;
    chk("t4_arb", 32'(grant), 0);
    nxt(); #2;
    chk("t4_grant", 32'(grant), 32'h08);
    chk("t4_sel",   32'(sel), 3);
    chk("t4_fwd",   32'(fwd), 1);
    nxt(); valid = '0;
    for (int i = 0; i < 8; i++) begin
      #2;
      chk("t4_hold_timeout", 32'(timeout), 0);
      chk("t4_hold_grant",   32'(grant), 32'h08);
      nxt();
    end
    #2;
    chk("t4_timeout", 32'(timeout), 1);
    chk("t4_grant0",  32'(grant), 0);
    chk("t4_sel0",    32'(sel), 0);
    nxt(); valid = 5'h1F; flit_id = ALL_HT; credit_in = 1'b1; #2;
    chk("t4_pulse_end", 32'(timeout), 0);
    nxt(); #2;
    chk("t4_next_is_s", 32'(grant), 32'h10);
    chk("t4_next_sel",  32'(sel), 4);
    nxt(); valid = '0; credit_in = 1'b0; #2;
    chk("t4_s_release", 32'(grant), 0);

    // single-flit packet from S, then reset in the middle of an E packet
    nxt(); valid = 5'b10000; flit_id = fid(4, 3'b101); #2;
    chk("t5_arb", 32'(grant), 0);
    nxt(); #2;
    chk("t5_s_grant", 32'(grant), 32'h10);
    chk("t5_s_fwd",   32'(fwd), 1);
    nxt(); valid = '0; #2;
    chk("t5_s_release", 32'(grant), 0);
    chk("t5_s_nofwd",   32'(fwd), 0);
    nxt(); valid = 5'b00100; flit_id = fid(2, 3'b001); #2;
    chk("t5_e_arb", 32'(grant), 0);
    nxt(); #2;
    chk("t5_e_grant", 32'(grant), 32'h04);
    chk("t5_e_fwd",   32'(fwd), 1);
    nxt(); flit_id = fid(2, 3'b010); rst = 1'b1; #2;
    chk("t5_rst_fwd", 32'(fwd), 0);
    nxt(); rst = 1'b0; #2;
    chk("t5_rst_grant",  32'(grant), 0);
    chk("t5_rst_sel",    32'(sel), 0);
    chk("t5_rst_credit", 32'(dut.r_credit_cnt), 4);
    chk("t5_post_fwd",   32'(fwd), 0);
    nxt(); valid = 5'h1F; flit_id = ALL_HT; #2;
    chk("t5_body_ignored", 32'(grant), 0);
    nxt(); #2;
    chk("t5_ptr_reset_l", 32'(grant), 32'h01);
    nxt(); valid = '0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
